// File: rtl/wb_stage.sv
// Write-back stage of the 5-stage MIPS pipeline.
// Selects the register-file write data, runs the SYSCALL services (display, halt),
// and keeps cycle and retired-instruction counters. halt is the FSM state output
// and holds every upstream pipeline register while it is 1.
//
// Flow control: there is no valid/ready pair in this stage. An instruction is
// present whenever ir_in != 0 (0 is a bubble). The only back-pressure is halt:
// while halt=1 upstream is frozen, so the inputs are stable, nothing is written
// and every registered output keeps its value until go returns the stage to RUN.
module wb_stage #(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] SYS_HALT = 32'd10,
  parameter logic [31:0] SYS_DISP = 32'd34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ir_in,
  input  logic [31:0]      pc_in,
  input  logic             lbu_in,
  input  logic             memtoreg_in,
  input  logic             regwrite_in,
  input  logic             jal_in,
  input  logic             syscall_in,
  input  logic [31:0]      result1_in,
  input  logic [31:0]      dout_in,
  input  logic [31:0]      r1_in,
  input  logic [31:0]      r2_in,
  input  logic [4:0]       w_num_in,
  input  logic             go,
  output logic             rf_we,
  output logic [4:0]       rf_wnum,
  output logic [31:0]      rf_wdata,
  output logic             halt,
  output logic [31:0]      disp,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nx;
  logic [31:0]      disp_nx;
  logic [CNT_W-1:0] cycle_nx;
  logic [CNT_W-1:0] retire_nx;
  logic [7:0]       load_byte;

  // State, display latch and counters; reset wins over go and syscall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      disp       <= 32'd0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      state      <= state_nx;
      disp       <= disp_nx;
      cycle_cnt  <= cycle_nx;
      retire_cnt <= retire_nx;
    end
  end

  // Next-state, syscall services and counter updates; HALT freezes everything.
  always_comb begin
    state_nx  = state;
    disp_nx   = disp;
    cycle_nx  = cycle_cnt;
    retire_nx = retire_cnt;
    case (state)
      RUN: begin
        cycle_nx = cycle_cnt + CNT_ONE;
        if (ir_in != 32'd0) begin
          retire_nx = retire_cnt + CNT_ONE;
        end
        if (syscall_in) begin
          if (r1_in == SYS_HALT) begin
            state_nx = HALT;
          end else if (r1_in == SYS_DISP) begin
            disp_nx = r2_in;
          end
        end
      end
      HALT: begin
        if (go) begin
          state_nx = RUN;
        end
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  // Byte lane picked by the low address bits for LBU (byte 0 = least significant).
  always_comb begin
    load_byte = dout_in[7:0];
    case (result1_in[1:0])
      2'd0: load_byte = dout_in[7:0];
      2'd1: load_byte = dout_in[15:8];
      2'd2: load_byte = dout_in[23:16];
      2'd3: load_byte = dout_in[31:24];
      default: load_byte = dout_in[7:0];
    endcase
  end

  // Write-back mux, priority jal > lbu > memtoreg > alu; writes to $0 are dropped.
  always_comb begin
    rf_wnum  = w_num_in;
    rf_wdata = result1_in;
    if (jal_in) begin
      rf_wnum  = 5'd31;
      rf_wdata = pc_in + 32'd4;
    end else if (lbu_in) begin
      rf_wdata = {24'd0, load_byte};
    end else if (memtoreg_in) begin
      rf_wdata = dout_in;
    end
    rf_we = regwrite_in && (state == RUN) && (rf_wnum != 5'd0);
  end

  assign halt = (state == HALT);

endmodule
